instruction_fetch_unit: RTL and testbench

//  Generates the program counter, issues word fetches to instruction memory and buffers

---
 rtl/instruction_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited imem requests, and an
// in-order instruction buffer feeding decode, with redirect flush and drain.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, discard, discard_next, count;
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   tag_q     [FIFO_DEPTH];

  logic          redirect, pop, grant, resp, drop, push;
  logic [SW-1:0] credit;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign redirect = redirect_valid & (state != IDLE);
  assign pop      = inst_valid & inst_ready;
  // A response with nothing in flight is a protocol error and is ignored.
  assign resp     = imem_rvalid & (outstanding != '0);
  assign drop     = redirect | (discard != '0);
  assign push     = resp & ~drop;

  // Buffered plus in-flight words must fit in the buffer, so a push never overflows.
  assign credit   = SW'(outstanding) + SW'(count) - SW'(pop);
  assign imem_req = (state == RUN) & ~redirect_valid & (credit < SW'(FIFO_DEPTH));
  assign grant    = imem_req & imem_gnt;
  assign imem_addr = pc;

  assign inst_valid = (count != '0);
  assign inst_out   = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    discard_next = discard;
    if (redirect)
      discard_next = outstanding - CW'(resp);
    else if (resp && (discard != '0))
      discard_next = discard - CW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (redirect && (discard_next != '0)) state_next = DRAIN;
      DRAIN:   if (discard_next == '0) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      // NOTE: the small buffer arrays are reset so inst_out/inst_pc read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        tag_q[i]     <= '0;
      end
    end else begin
      state       <= state_next;
      discard     <= discard_next;
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (redirect) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        tag_rd <= '0;
        tag_wr <= '0;
      end else begin
        if (grant) begin
          pc            <= pc + 32'd4;
          tag_q[tag_wr] <= pc;
          tag_wr        <= tag_wr + AW'(1);
        end
        if (push) begin
          fifo_data[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          wr_ptr            <= wr_ptr + AW'(1);
          tag_rd            <= tag_rd + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirect
// drain/collision, PC wrap from a high RESET_PC and asynchronous reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, inst_out, inst_pc;

  logic        req2, valid2;
  logic [31:0] addr2, out2, pc2;

  bit          auto_mem = 1'b0;
  logic        auto_rvalid = 1'b0, man_rvalid = 1'b0;
  logic [31:0] auto_rdata = '0, man_rdata = '0;
  logic        pend_g;
  logic [31:0] pend_a;

  logic [31:0] grants [$];
  logic [63:0] pops   [$];
  int          n_checks = 0;
  int          n_pass = 0;

  assign imem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
  assign imem_rdata  = auto_mem ? auto_rdata  : man_rdata;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(valid2), .inst_ready(1'b0),
    .inst_out(out2), .inst_pc(pc2)
  );

  always #5 clk = ~clk;

  // Observe at the falling edge; a 1-cycle memory answers each grant with ~addr.
  always @(negedge clk) begin
    pend_g = auto_mem && imem_req && imem_gnt;
    pend_a = imem_addr;
    if (!reset && imem_req && imem_gnt) grants.push_back(imem_addr);
    if (!reset && inst_valid && inst_ready) pops.push_back({inst_pc, inst_out});
  end

  always @(posedge clk) begin
    if (auto_mem) begin
      #1;
      auto_rvalid = pend_g;
      auto_rdata  = ~pend_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset(input bit am);
    reset = 1'b1;
    auto_mem = am;
    man_rvalid = 1'b0;
    man_rdata = '0;
    imem_gnt = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    grants.delete();
    pops.delete();
  endtask

  task automatic test_reset();
    imem_gnt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step();
    step();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (inst_out !== 32'h0) $display("FAIL reset_out: got %h want 0", inst_out); else n_pass++;
    n_checks++; if (inst_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", inst_pc); else n_pass++;
    n_checks++; if (addr2 !== 32'hFFFF_FFF8) $display("FAIL reset_addr_wrap: got %h want fffffff8", addr2); else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    inst_ready = 1'b1;
    step();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL stream_first_req: got %b/%h want 1/0", imem_req, imem_addr); else n_pass++;
    step();
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL stream_no_fallthrough: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (imem_addr !== 32'h4) $display("FAIL stream_addr2: got %h want 4", imem_addr); else n_pass++;
    step();
    n_checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, 32'hFFFF_FFFF})
      $display("FAIL stream_first_inst: got %b/%h/%h want 1/0/ffffffff", inst_valid, inst_pc, inst_out); else n_pass++;
    repeat (10) step();
    n_checks++; if (pops.size() !== 10) $display("FAIL stream_rate: got %0d pops want 10", pops.size()); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      n_checks++; if (pops[i] !== {a, ~a}) $display("FAIL stream_pop%0d: got %h want %h", i, pops[i], {a, ~a}); else n_pass++;
      n_checks++; if (grants[i] !== a) $display("FAIL stream_grant%0d: got %h want %h", i, grants[i], a); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b1);
    repeat (10) step();
    n_checks++; if (grants.size() !== 4) $display("FAIL bp_grants: got %0d want 4", grants.size()); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_req_off: got %b want 0", imem_req); else n_pass++;
    n_checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, 32'hFFFF_FFFF})
      $display("FAIL bp_hold: got %b/%h/%h want 1/0/ffffffff", inst_valid, inst_pc, inst_out); else n_pass++;
    inst_ready = 1'b1;
    #1;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL bp_resume_req: got %b/%h want 1/10", imem_req, imem_addr); else n_pass++;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      n_checks++; if (pops[i] !== {a, ~a}) $display("FAIL bp_pop%0d: got %h want %h", i, pops[i], {a, ~a}); else n_pass++;
    end
    n_checks++; if (grants[4] !== 32'h10) $display("FAIL bp_grant16: got %h want 10", grants[4]); else n_pass++;
  endtask

  task automatic test_redirect_drain();
    apply_reset(1'b0);
    inst_ready = 1'b1;
    step(); step(); step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rd_req_on_redirect: got %b want 0", imem_req); else n_pass++;
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    n_checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h100}) $display("FAIL rd_drain: got %b/%h want 0/100", imem_req, imem_addr); else n_pass++;
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_0000;
    step();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rd_still_drain: got %b want 0", imem_req); else n_pass++;
    man_rdata = 32'hDEAD_0004;
    step();
    man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL rd_resume: got %b/%b/%h want 0/1/100", inst_valid, imem_req, imem_addr); else n_pass++;
    step();
    man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rd_dropped: got %b want 0", inst_valid); else n_pass++;
    step();
    man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h100, 32'h1234_5678})
      $display("FAIL rd_first_inst: got %b/%h/%h want 1/100/12345678", inst_valid, inst_pc, inst_out); else n_pass++;
    n_checks++; if (grants[2] !== 32'h100) $display("FAIL rd_grant_addr: got %h want 100", grants[2]); else n_pass++;
  endtask

  task automatic test_redirect_collision();
    apply_reset(1'b0);
    step(); step(); step();
    man_rvalid = 1'b1; man_rdata = 32'hAAAA_0000;
    step();
    imem_gnt = 1'b0; man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) $display("FAIL col_setup: got %b/%h want 1/0", inst_valid, inst_pc); else n_pass++;
    inst_ready = 1'b1;
    man_rvalid = 1'b1; man_rdata = 32'hBBBB_0004;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0; man_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL col_flush: got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (pops.size() !== 1 || pops[0] !== {32'h0, 32'hAAAA_0000})
      $display("FAIL col_pop: got %0d pops first %h want 1 pop 00000000aaaa0000", pops.size(), pops[0]); else n_pass++;
    n_checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h200}) $display("FAIL col_drain: got %b/%h want 0/200", imem_req, imem_addr); else n_pass++;
    man_rvalid = 1'b1; man_rdata = 32'hCCCC_0008;
    imem_gnt = 1'b1;
    step();
    man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL col_resume: got %b/%b/%h want 0/1/200", inst_valid, imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_reset_pc_wrap();
    apply_reset(1'b0);
    step();
    n_checks++; if ({req2, addr2} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL wrap_a0: got %b/%h want 1/fffffff8", req2, addr2); else n_pass++;
    step();
    n_checks++; if (addr2 !== 32'hFFFF_FFFC) $display("FAIL wrap_a1: got %h want fffffffc", addr2); else n_pass++;
    step();
    n_checks++; if (addr2 !== 32'h0) $display("FAIL wrap_a2: got %h want 0", addr2); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    apply_reset(1'b1);
    repeat (10) step();
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL rst_full_setup: got %b want 1", inst_valid); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({inst_valid, imem_req, inst_pc, inst_out, imem_addr} !== {1'b0, 1'b0, 96'h0})
      $display("FAIL rst_async_full: got %b/%b/%h/%h/%h want 0/0/0/0/0", inst_valid, imem_req, inst_pc, inst_out, imem_addr); else n_pass++;
    step();
    auto_mem = 1'b0; man_rvalid = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
    reset = 1'b0;
    step(); step(); step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    n_checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h40}) $display("FAIL rst_drain_setup: got %b/%h want 0/40", imem_req, imem_addr); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h0}) $display("FAIL rst_async_drain: got %b/%h want 0/0", imem_req, imem_addr); else n_pass++;
    step();
    reset = 1'b0; imem_gnt = 1'b1;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    step();
    man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL rst_restart: got %b/%b/%h want 0/1/0", inst_valid, imem_req, imem_addr); else n_pass++;
    step();
    man_rvalid = 1'b1; man_rdata = 32'h0000_0055;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_stray_ignored: got %b want 0", inst_valid); else n_pass++;
    step();
    man_rvalid = 1'b0;
    n_checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, 32'h55})
      $display("FAIL rst_refetch: got %b/%h/%h want 1/0/55", inst_valid, inst_pc, inst_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_reset_pc_wrap();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
